// File: rtl/vend_ctrl_param.sv
// Parametrised coin-accumulating vending controller with vend strobe, change/refund handshake
// and saturating vend counter. Define VEND_CHANGE_EN to return overpayment through CHANGE.
module vend_ctrl_param #(
   parameter int PRICE    = 3,
   parameter int CREDIT_W = 4,
   parameter int CNT_W    = 8
) (
   input  logic                clock,
   input  logic                reset,
   input  logic [1:0]          coin,
   input  logic                cancel,
   input  logic                change_ready,
   output logic                vend,
   output logic                busy,
   output logic [CREDIT_W-1:0] credit,
   output logic                change_valid,
   output logic [CREDIT_W-1:0] change_amt,
   output logic [CNT_W-1:0]    vend_count
);

   typedef enum logic [1:0] {IDLE, ACCUM, VEND, CHANGE} state_t;

   localparam logic [CREDIT_W:0] PRICE_EXT = (CREDIT_W+1)'(PRICE);

   state_t              state;
   logic [CREDIT_W:0]   coin_val;
   logic [CREDIT_W:0]   sum;

   always_comb begin
      coin_val = '0;
      case (coin)
         2'b01:   coin_val = (CREDIT_W+1)'(1);
         2'b10:   coin_val = (CREDIT_W+1)'(2);
         2'b11:   coin_val = (CREDIT_W+1)'(5);
         default: coin_val = '0;
      endcase
      // One bit wider than credit so the price comparison cannot wrap
      sum = {1'b0, credit} + coin_val;
   end

`ifdef VEND_CHANGE_EN
   logic [CREDIT_W-1:0] excess;
   logic [CREDIT_W:0]   over;
   assign over = sum - PRICE_EXT;
`endif

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state        <= IDLE;
         credit       <= '0;
         change_amt   <= '0;
         vend_count   <= '0;
         vend         <= 1'b0;
         busy         <= 1'b0;
         change_valid <= 1'b0;
`ifdef VEND_CHANGE_EN
         excess       <= '0;
`endif
      end else begin
         case (state)
            IDLE, ACCUM: begin
               // Cancel has priority; a same-cycle coin is folded into the refund
               if (cancel && sum != '0) begin
                  state        <= CHANGE;
                  change_amt   <= sum[CREDIT_W-1:0];
                  credit       <= '0;
                  change_valid <= 1'b1;
                  busy         <= 1'b1;
               end else if (sum >= PRICE_EXT) begin
                  state  <= VEND;
                  credit <= '0;
                  vend   <= 1'b1;
                  busy   <= 1'b1;
                  if (vend_count != '1)
                     vend_count <= vend_count + 1'b1;
`ifdef VEND_CHANGE_EN
                  excess <= over[CREDIT_W-1:0];
`endif
               end else if (coin != 2'b00) begin
                  state  <= ACCUM;
                  credit <= sum[CREDIT_W-1:0];
               end
            end
            VEND: begin
               vend <= 1'b0;
`ifdef VEND_CHANGE_EN
               if (excess != '0) begin
                  state        <= CHANGE;
                  change_amt   <= excess;
                  change_valid <= 1'b1;
               end else begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
`else
               state <= IDLE;
               busy  <= 1'b0;
`endif
            end
            CHANGE: begin
               if (change_ready) begin
                  state        <= IDLE;
                  change_amt   <= '0;
                  change_valid <= 1'b0;
                  busy         <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
